// File: rtl/arm_verilog_serial_out.sv
// Transmit-only serial output buffer: latches a 7-bit address and 8-bit data word on Go
// and sends them MSB-first as a framed two-wire stream (start, 15 clocked bits, stop).
module arm_verilog_serial_out (
   output logic       OutD,
   output logic       OutC,
   input  logic [7:0] D,
   input  logic [6:0] A,
   input  logic       Go,
   input  logic       clk_in,
   input  logic       reset_n
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_SHIFT = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t      state_r;
   logic [14:0] shift_r;
   logic [3:0]  cnt_r;
   logic        phase_r;

   // Frame sequencer; outputs are registered and reflect the state handled at each edge.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         shift_r <= 15'd0;
         cnt_r   <= 4'd0;
         phase_r <= 1'b0;
         OutD    <= 1'b1;
         OutC    <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               OutD    <= 1'b1;
               OutC    <= 1'b1;
               phase_r <= 1'b0;
               if (Go) begin
                  shift_r <= {A, D};
                  cnt_r   <= 4'd0;
                  state_r <= ST_START;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_START: begin
               OutD    <= 1'b0;
               OutC    <= 1'b1;
               phase_r <= 1'b0;
               cnt_r   <= 4'd0;
               state_r <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // Data only moves in the low phase so it is stable across the OutC rise.
               if (!phase_r) begin
                  OutC    <= 1'b0;
                  OutD    <= shift_r[14];
                  phase_r <= 1'b1;
               end else begin
                  OutC    <= 1'b1;
                  phase_r <= 1'b0;
                  shift_r <= {shift_r[13:0], 1'b0};
                  if (cnt_r == 4'd14) begin
                     cnt_r   <= 4'd0;
                     state_r <= ST_STOP;
                  end else begin
                     cnt_r   <= cnt_r + 4'd1;
                  end
               end
            end
            ST_STOP: begin
               OutD <= 1'b0;
               if (!phase_r) begin
                  OutC    <= 1'b0;
                  phase_r <= 1'b1;
               end else begin
                  OutC    <= 1'b1;
                  phase_r <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               OutD    <= 1'b1;
               OutC    <= 1'b1;
               phase_r <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arm_verilog_serial_out.sv
// Directed self-checking bench for arm_verilog_serial_out: reset, frame content/timing,
// busy-ignore, back-to-back and mid-frame reset.
module tb_arm_verilog_serial_out;

   logic       clk;
   logic       reset_n;
   logic       out_d;
   logic       out_c;
   logic [7:0] d;
   logic [6:0] a;
   logic       go;

   int pass_cnt  = 0;
   int total_cnt = 0;

   arm_verilog_serial_out dut (
      .OutD   (out_d),
      .OutC   (out_c),
      .D      (d),
      .A      (a),
      .Go     (go),
      .clk_in (clk),
      .reset_n(reset_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observes edges E+1..E+34 after a Go edge E and summarises what the line did.
   task automatic capture(input int pulse_at, input logic keep_go,
                          output logic start_ok, output logic [14:0] bits,
                          output int rises, output logic stop_ok, output int viol);
      logic prev_c;
      logic prev_d;
      prev_c   = out_c;
      prev_d   = out_d;
      start_ok = 1'b0;
      stop_ok  = 1'b1;
      bits     = 15'd0;
      rises    = 0;
      viol     = 0;
      for (int i = 1; i <= 34; i++) begin
         go = keep_go ? 1'b1 : (i == pulse_at);
         tick();
         if (i == 1) start_ok = (out_d === 1'b0) && (out_c === 1'b1);
         if (i == 32 && !(out_d === 1'b0 && out_c === 1'b0)) stop_ok = 1'b0;
         if (i == 33 && !(out_d === 1'b0 && out_c === 1'b1)) stop_ok = 1'b0;
         if (i == 34 && !(out_d === 1'b1 && out_c === 1'b1)) stop_ok = 1'b0;
         if (i > 1 && i < 34 && prev_c === 1'b1 && out_c === 1'b1 && out_d !== prev_d) viol++;
         if (prev_c === 1'b0 && out_c === 1'b1 && i < 32) begin
            bits = {bits[13:0], out_d};
            rises++;
         end
         prev_c = out_c;
         prev_d = out_d;
      end
      go = keep_go;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      go      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = (i % 2 == 0) ? 7'h7F : 7'h00;
         d = (i % 2 == 0) ? 8'hFF : 8'h00;
         tick();
         total_cnt++;
         if ({out_d, out_c} !== 2'b11) $display("FAIL reset_hold[%0d]: got %b want 11", i, {out_d, out_c});
         else pass_cnt++;
      end
      go      = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if ({out_d, out_c} !== 2'b11) $display("FAIL reset_release[%0d]: got %b want 11", i, {out_d, out_c});
         else pass_cnt++;
      end
   endtask

   task automatic test_all_ones();
      logic sok, pok;
      logic [14:0] bits;
      int rises, viol;
      a = 7'h7F; d = 8'hFF; go = 1'b1;
      tick();
      go = 1'b0;
      capture(0, 1'b0, sok, bits, rises, pok, viol);
      total_cnt++;
      if (sok !== 1'b1) $display("FAIL ones_start: got %b want 1", sok); else pass_cnt++;
      total_cnt++;
      if (bits !== 15'h7FFF) $display("FAIL ones_bits: got %h want 7fff", bits); else pass_cnt++;
      total_cnt++;
      if (rises != 15) $display("FAIL ones_rises: got %0d want 15", rises); else pass_cnt++;
      total_cnt++;
      if (pok !== 1'b1) $display("FAIL ones_stop: got %b want 1", pok); else pass_cnt++;
      total_cnt++;
      if (viol != 0) $display("FAIL ones_d_stable: got %0d want 0", viol); else pass_cnt++;
   endtask

   task automatic test_pattern();
      logic sok, pok;
      logic [14:0] bits;
      int rises, viol;
      a = 7'h55; d = 8'hA3; go = 1'b1;
      tick();
      go = 1'b0; a = 7'h00; d = 8'h00;
      capture(0, 1'b0, sok, bits, rises, pok, viol);
      total_cnt++;
      if (bits !== 15'b1010101_10100011) $display("FAIL pattern_bits: got %b want 101010110100011", bits);
      else pass_cnt++;
      total_cnt++;
      if (sok !== 1'b1 || pok !== 1'b1 || rises != 15 || viol != 0)
         $display("FAIL pattern_frame: got start=%b stop=%b rises=%0d viol=%0d want 1 1 15 0", sok, pok, rises, viol);
      else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      logic sok, pok;
      logic [14:0] bits;
      int rises, viol;
      a = 7'h2A; d = 8'h5C; go = 1'b1;
      tick();
      go = 1'b0; a = 7'h11; d = 8'h22;
      capture(10, 1'b0, sok, bits, rises, pok, viol);
      total_cnt++;
      if (bits !== 15'h2A5C) $display("FAIL busy_bits: got %h want 2a5c", bits); else pass_cnt++;
      total_cnt++;
      if (pok !== 1'b1 || rises != 15) $display("FAIL busy_frame: got stop=%b rises=%0d want 1 15", pok, rises);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if ({out_d, out_c} !== 2'b11) $display("FAIL busy_no_restart[%0d]: got %b want 11", i, {out_d, out_c});
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic sok, pok;
      logic [14:0] bits;
      int rises, viol;
      a = 7'h01; d = 8'h80; go = 1'b1;
      tick();
      a = 7'h40; d = 8'h01;
      capture(0, 1'b1, sok, bits, rises, pok, viol);
      total_cnt++;
      if (bits !== 15'h0180) $display("FAIL b2b_first_bits: got %h want 0180", bits); else pass_cnt++;
      total_cnt++;
      if (pok !== 1'b1) $display("FAIL b2b_idle_gap: got %b want 1", pok); else pass_cnt++;
      capture(0, 1'b0, sok, bits, rises, pok, viol);
      total_cnt++;
      if (sok !== 1'b1) $display("FAIL b2b_second_start: got %b want 1", sok); else pass_cnt++;
      total_cnt++;
      if (bits !== 15'h4001) $display("FAIL b2b_second_bits: got %h want 4001", bits); else pass_cnt++;
      tick();
      total_cnt++;
      if ({out_d, out_c} !== 2'b11) $display("FAIL b2b_end_idle: got %b want 11", {out_d, out_c});
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      logic sok, pok;
      logic [14:0] bits;
      int rises, viol;
      a = 7'h00; d = 8'h00; go = 1'b1;
      tick();
      go = 1'b0;
      for (int i = 1; i <= 11; i++) tick();
      total_cnt++;
      if (out_c !== 1'b1 || out_d !== 1'b0) $display("FAIL midrst_in_frame: got %b want 01", {out_d, out_c});
      else pass_cnt++;
      reset_n = 1'b0;
      for (int i = 12; i <= 13; i++) begin
         tick();
         total_cnt++;
         if ({out_d, out_c} !== 2'b11) $display("FAIL midrst_abort[E+%0d]: got %b want 11", i, {out_d, out_c});
         else pass_cnt++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if ({out_d, out_c} !== 2'b11) $display("FAIL midrst_idle[%0d]: got %b want 11", i, {out_d, out_c});
         else pass_cnt++;
      end
      a = 7'h3C; d = 8'hC3; go = 1'b1;
      tick();
      go = 1'b0;
      capture(0, 1'b0, sok, bits, rises, pok, viol);
      total_cnt++;
      if (bits !== 15'h3CC3) $display("FAIL midrst_new_bits: got %h want 3cc3", bits); else pass_cnt++;
      total_cnt++;
      if (sok !== 1'b1 || pok !== 1'b1 || rises != 15 || viol != 0)
         $display("FAIL midrst_new_frame: got start=%b stop=%b rises=%0d viol=%0d want 1 1 15 0", sok, pok, rises, viol);
      else pass_cnt++;
   endtask

   initial begin
      reset_n = 1'b0;
      go      = 1'b0;
      a       = 7'h00;
      d       = 8'h00;
      test_reset();
      test_all_ones();
      test_pattern();
      test_busy_ignore();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
